multdiv_ctrl: RTL



---
 rtl/multdiv_ctrl_if.sv | 49 ++++
 rtl/multdiv_ctrl.sv | 134 +++++++++++++
 2 files changed

// File: rtl/multdiv_ctrl_if.sv
// Bundle between multdiv_ctrl and its neighbours: pipeline request, multdiv unit, writeback.
// slave  : the controller (takes requests, drives multdiv operands/starts and writeback).
// master : the surrounding pipeline / multdiv / writeback side.
interface multdiv_ctrl_if #(
   parameter int TAG_W = 5
);
   // pipeline request
   logic             req_valid;
   logic             req_is_div;
   logic [31:0]      req_a;
   logic [31:0]      req_b;
   logic [TAG_W-1:0] req_tag;
   logic             req_ready;
   logic             flush;
   logic             busy;
   // multdiv unit
   logic [31:0]      md_operandA;
   logic [31:0]      md_operandB;
   logic             md_ctrl_MULT;
   logic             md_ctrl_DIV;
   logic [31:0]      md_result;
   logic             md_exception;
   logic             md_resultRDY;
   // writeback
   logic             wb_valid;
   logic             wb_ready;
   logic [31:0]      wb_result;
   logic             wb_exception;
   logic [TAG_W-1:0] wb_tag;
   logic             wb_timeout;

   modport slave (
      input  req_valid, req_is_div, req_a, req_b, req_tag, flush,
      output req_ready, busy,
      output md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
      input  md_result, md_exception, md_resultRDY,
      output wb_valid, wb_result, wb_exception, wb_tag, wb_timeout,
      input  wb_ready
   );

   modport master (
      output req_valid, req_is_div, req_a, req_b, req_tag, flush,
      input  req_ready, busy,
      input  md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
      output md_result, md_exception, md_resultRDY,
      input  wb_valid, wb_result, wb_exception, wb_tag, wb_timeout,
      output wb_ready
   );
endinterface

// File: rtl/multdiv_ctrl.sv
// Purpose : sequences one multiply/divide through the multi-cycle multdiv unit, holding
//           operands stable, issuing the start pulse and handing the result to writeback.
// Latency : accept -> START pulse next cycle -> WAIT; wb_valid the cycle after the first
//           md_resultRDY seen in WAIT (18 cycles with a 16-cycle multdiv); divide-by-zero 1 cycle.
// Backpressure: one op in flight; req_ready low while busy; wb_* held stable until wb_ready.
// Ports   : clock, reset_n (async active-low), bus (multdiv_ctrl_if.slave).
// Option  : define MULTDIV_CTRL_TIMEOUT_EN to enable the WAIT-state watchdog (TIMEOUT_CYCLES).
module multdiv_ctrl #(
   parameter int TAG_W          = 5,
   parameter int TIMEOUT_CYCLES = 64
) (
   input logic           clock,
   input logic           reset_n,
   multdiv_ctrl_if.slave bus
);

   typedef enum logic [1:0] {IDLE, START, WAIT, HOLD} state_t;

   state_t           state, state_nxt;
   logic             accept;
   logic             div_zero;
   logic             timeout_hit;

   logic [31:0]      op_a_q, op_b_q;
   logic [TAG_W-1:0] tag_q;
   logic             md_mult_q, md_div_q;
   logic             wb_valid_q;
   logic [31:0]      wb_result_q;
   logic             wb_exc_q;
   logic             wb_timeout_q;

   assign accept   = (state == IDLE) & bus.req_valid & ~bus.flush;
   assign div_zero = bus.req_is_div & (bus.req_b == 32'd0);

`ifdef MULTDIV_CTRL_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_cnt;

   // Count reads k-1 in the k-th WAIT cycle, so the last allowed WAIT cycle sees TIMEOUT_CYCLES-1.
   assign timeout_hit = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wd_cnt       <= '0;
         wb_timeout_q <= 1'b0;
      end else begin
         if (state == START)
            wd_cnt <= '0;
         else if (state == WAIT)
            wd_cnt <= wd_cnt + 1'b1;

         if ((state == WAIT) && !bus.flush && !bus.md_resultRDY && timeout_hit)
            wb_timeout_q <= 1'b1;
         else if (bus.flush || ((state == HOLD) && bus.wb_ready))
            wb_timeout_q <= 1'b0;
      end
   end
`else
   logic [31:0] unused_timeout_cfg;
   assign unused_timeout_cfg = TIMEOUT_CYCLES;
   assign timeout_hit        = 1'b0;
   assign wb_timeout_q       = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (accept) state_nxt = div_zero ? HOLD : START;
         // Ready is not looked at here: multdiv's counter may still show a stale done.
         START: state_nxt = bus.flush ? IDLE : WAIT;
         WAIT: begin
            if (bus.flush)
               state_nxt = IDLE;
            else if (bus.md_resultRDY || timeout_hit)
               state_nxt = HOLD;
         end
         HOLD:  if (bus.flush || bus.wb_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         op_a_q      <= '0;
         op_b_q      <= '0;
         tag_q       <= '0;
         md_mult_q   <= 1'b0;
         md_div_q    <= 1'b0;
         wb_valid_q  <= 1'b0;
         wb_result_q <= '0;
         wb_exc_q    <= 1'b0;
      end else begin
         state      <= state_nxt;
         // Start pulses are set only on the accepting edge, so they last exactly the START cycle.
         md_mult_q  <= accept & ~div_zero & ~bus.req_is_div;
         md_div_q   <= accept & ~div_zero &  bus.req_is_div;
         wb_valid_q <= (state_nxt == HOLD);

         if (accept) begin
            op_a_q <= bus.req_a;
            op_b_q <= bus.req_b;
            tag_q  <= bus.req_tag;
            if (div_zero) begin
               wb_result_q <= '0;
               wb_exc_q    <= 1'b1;
            end
         end

         if ((state == WAIT) && !bus.flush) begin
            if (bus.md_resultRDY) begin
               wb_result_q <= bus.md_result;
               wb_exc_q    <= bus.md_exception;
            end else if (timeout_hit) begin
               wb_result_q <= '0;
               wb_exc_q    <= 1'b1;
            end
         end
      end
   end

   assign bus.busy         = (state != IDLE);
   assign bus.req_ready    = (state == IDLE) & ~bus.flush;
   assign bus.md_operandA  = op_a_q;
   assign bus.md_operandB  = op_b_q;
   assign bus.md_ctrl_MULT = md_mult_q;
   assign bus.md_ctrl_DIV  = md_div_q;
   assign bus.wb_valid     = wb_valid_q;
   assign bus.wb_result    = wb_result_q;
   assign bus.wb_exception = wb_exc_q;
   assign bus.wb_tag       = tag_q;
   assign bus.wb_timeout   = wb_timeout_q;

endmodule
